// File: rtl/clk_div_multi.sv
// Multi-channel programmable 50%-duty clock divider with a single-slot half-period update port.
// Optional CLK_DIV_MULTI_TICK_EN adds registered per-channel rising-edge tick pulses.
module clk_div_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 6000000,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] boundary, restart, apply;
  logic              pend_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [CNT_W-1:0]  pend_half_q;
  logic              err_q;
  logic              accept, bad_ch;

  assign cfg_ready = ~pend_q;
  assign accept    = cfg_valid & cfg_ready;
  assign bad_ch    = 32'(cfg_ch) >= NUM_CH;

  always_comb begin
    boundary = '0;
    restart  = '0;
    apply    = '0;
    clk_d    = clk_q;
    for (int i = 0; i < NUM_CH; i++) begin
      boundary[i] = en[i] && (half_q[i] != '0) && (cnt_q[i] == half_q[i] - CNT_W'(1));
      // Counter returns to zero when idle, stalled (H=0) or at a half-period boundary.
      restart[i]  = !en[i] || (half_q[i] == '0) || boundary[i];
      apply[i]    = pend_q && (pend_ch_q == CH_W'(i)) &&
                    (!en[i] || (half_q[i] == '0) || boundary[i]);
      if (!en[i]) begin
        clk_d[i] = 1'b0;
      end else if (boundary[i]) begin
        clk_d[i] = ~clk_q[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        half_q[i] <= CNT_W'(DEFAULT_HALF);
        cnt_q[i]  <= '0;
      end
      clk_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          half_q[i] <= pend_half_q;
        end
        cnt_q[i] <= restart[i] ? '0 : cnt_q[i] + CNT_W'(1);
      end
      clk_q <= clk_d;
    end
  end

  // Out-of-range channels are accepted but never occupy the slot.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_half_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= accept & bad_ch;
      if (|apply) begin
        pend_q <= 1'b0;
      end
      if (accept && !bad_ch) begin
        pend_q      <= 1'b1;
        pend_ch_q   <= cfg_ch;
        pend_half_q <= cfg_half;
      end
    end
  end

  assign cfg_err = err_q;
  assign clk_out = clk_q;

`ifdef CLK_DIV_MULTI_TICK_EN
  logic [NUM_CH-1:0] tick_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= clk_d & ~clk_q;
    end
  end

  assign tick = tick_q;
`else
  assign tick = '0;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed plus randomized bench for clk_div_multi against a countdown-based reference model.
module tb_clk_div_multi;

  localparam int unsigned NCH  = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned DH   = 3;
  localparam int unsigned CHW  = 2;

  logic           clk_in = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_half;
  logic           cfg_err;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per channel a half-period, cycles remaining to next toggle, and level.
  int unsigned    m_half [NCH];
  int unsigned    m_rem  [NCH];
  logic [NCH-1:0] m_lvl;
  logic [NCH-1:0] m_tick;
  bit             m_pend;
  int unsigned    m_ch;
  int unsigned    m_new;
  bit             m_err;

  clk_div_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_HALF(DH)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_half[i] = DH;
      m_rem[i]  = DH;
    end
    m_lvl  = '0;
    m_tick = '0;
    m_pend = 0;
    m_err  = 0;
  endtask

  // One clock edge of the reference model using the inputs held across that edge.
  task automatic model_edge();
    bit             was_pend = m_pend;
    bit             applied  = 0;
    logic [NCH-1:0] prev     = m_lvl;
    for (int i = 0; i < NCH; i++) begin
      bit tgt = was_pend && (m_ch == i);
      if (!en[i] || m_half[i] == 0) begin
        if (!en[i]) m_lvl[i] = 1'b0;
        if (tgt) begin
          m_half[i] = m_new;
          applied   = 1;
        end
        m_rem[i] = m_half[i];
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_lvl[i] = ~m_lvl[i];
          if (tgt) begin
            m_half[i] = m_new;
            applied   = 1;
          end
          m_rem[i] = m_half[i];
        end
      end
    end
    m_tick = m_lvl & ~prev;
    if (applied) m_pend = 0;
    m_err = 0;
    if (cfg_valid && !was_pend) begin
      if (int'(cfg_ch) >= NCH) begin
        m_err = 1;
      end else begin
        m_pend = 1;
        m_ch   = int'(cfg_ch);
        m_new  = int'(cfg_half);
      end
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] exp_tick;
`ifdef CLK_DIV_MULTI_TICK_EN
    exp_tick = m_tick;
`else
    exp_tick = '0;
`endif
    chk("clk_out", 32'(clk_out), 32'(m_lvl));
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      model_edge();
      @(negedge clk_in);
      check_all();
    end
  endtask

  task automatic send(input int ch, input int half);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_half  = CW'(half);
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_half  = '0;
    model_reset();
    #12;
    chk("reset_clk_out", 32'(clk_out), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    chk("reset_err", 32'(cfg_err), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    step(2);

    // All channels enabled from reset: first rise three edges after enable.
    en = '1;
    step(2);
    chk("pre_rise", 32'(clk_out), 32'h0);
    step(1);
    chk("first_rise", 32'(clk_out), 32'h7);
    step(24);

    // Mid-half-period update of channel 0 waits for the boundary.
    step(1);
    send(0, 5);
    chk("ready_low_pending", 32'(cfg_ready), 32'h0);
    step(30);

    // Update to a disabled channel applies next cycle, then runs at clk_in/2.
    en = 3'b101;
    step(3);
    send(1, 1);
    step(2);
    en = 3'b111;
    step(10);

    // Out-of-range channel is flagged and discarded.
    send(3, 9);
    chk("err_pulse", 32'(cfg_err), 32'h1);
    chk("err_ready", 32'(cfg_ready), 32'h1);
    step(1);
    chk("err_single", 32'(cfg_err), 32'h0);
    step(8);

    // Reset while an update is pending and channel 0 is high.
    send(0, 7);
    for (int k = 0; k < 20 && !m_lvl[0]; k++) step(1);
    chk("ch0_high_before_rst", 32'(clk_out[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_clk_out", 32'(clk_out), 32'h0);
    chk("async_rst_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk_in);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_ready", 32'(cfg_ready), 32'h1);
    step(12);

    // Randomized enables and configuration traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) en = NCH'($urandom);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CHW'($urandom_range(0, 3));
      cfg_half  = CW'($urandom_range(0, 7));
      step(1);
    end
    cfg_valid = 1'b0;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
